pueo_trig_rx_merge: RTL and testbench
=====================================

// Module: pueo_trig_rx_merge
// PURPOSE
//  Sysclk-domain receiver for the three TURF software-trigger streams (soft, pps, ext) produced by the trigger controller.
//  Each stream is an addr/metadata/valid triplet; valid is held 4 clocks in an 8-clock sysclk_phase_i frame.
//  Captures each stream on the valid rising edge and checks its alignment and metadata sequence.
//  Merges the streams round-robin onto one valid/ready trigger stream for the event builder.
// PARAMETERS
//  PHASE_OFFSET  3   clocks from sysclk_phase_i high to the expected valid rising edge
//  ADDR_BITS     12  trigger address width
//  META_BITS     8   metadata width; [7] is the run marker, [6:0] is the sequence number
//  CNT_BITS      16  width of each drop counter (saturating)
// PORTS
//  sysclk_i           in   1   system clock; single clock domain
//  rst_i              in   1   reset, asynchronous, active-high
//  sysclk_phase_i     in   1   1-clock pulse every 8 clocks
//  running_i          in   1   run active; captures ignored while low
//  clear_err_i        in   1   pulse: clear sticky errors and drop counters
//  turf_soft_trig_i   in   12  soft trigger address     | turf_soft_metadata_i in 8 | turf_soft_valid_i in 1
//  turf_pps_trig_i    in   12  pps trigger address      | turf_pps_metadata_i  in 8 | turf_pps_valid_i  in 1
//  turf_ext_trig_i    in   12  ext trigger address      | turf_ext_metadata_i  in 8 | turf_ext_valid_i  in 1
//  m_trig_tdata       out  22  {src[1:0], metadata[7:0], addr[11:0]}; src 0=soft 1=pps 2=ext
//  m_trig_tvalid      out  1   output entry valid
//  m_trig_tready      in   1   downstream accept
//  drop_count_o       out  48  {ext, pps, soft} CNT_BITS saturating counts of dropped captures
//  seq_err_o          out  3   sticky per-source sequence error, bit = src index
//  align_err_o        out  3   sticky per-source phase-alignment error
// BEHAVIOUR
//  Reset: all outputs 0; holding slots empty; expected sequence 0; round-robin pointer = 0.
//  Phase counter:
//   - Reloads on sysclk_phase_i.
//   - Its "aligned" strobe fires exactly PHASE_OFFSET clocks after sysclk_phase_i.
//  Capture (per source):
//   - Condition: valid_i & ~valid_q & running_i, where valid_q is valid_i registered.
//   - Latches addr and meta on that cycle (E); the slot is full at E+1.
//   - Valid held high 4 clocks yields exactly one capture; valid high while running_i low is ignored.
//  Alignment: capture cycle != aligned strobe -> set align_err_o[src]; the entry is still kept.
//  Sequence check (per source):
//   - Expected seq resets to 0 while running_i is low.
//   - Mismatch -> set seq_err_o[src] and resync expected to meta[6:0]+1; otherwise expected = meta[6:0]+1 mod 128.
//   - Capture with meta[7]==0 -> set seq_err_o[src].
//  Slot full (per source):
//   - Capture into a full slot that is not being granted in the same cycle -> capture dropped, old entry kept,
//     drop_count[src]+1, saturating at all-ones.
//   - Grant and capture in the same cycle -> slot reloads with the new entry, no drop.
//  Arbiter and output register:
//   - Output register loads when (~m_trig_tvalid | m_trig_tready) and any slot is full.
//   - Grant goes to the first full slot at or after the pointer; the pointer then moves to grant+1 mod 3.
//   - Latency: capture at E -> m_trig_tvalid at E+2 at the earliest.
//   - tdata/tvalid hold stable while tvalid & ~tready; a tvalid/tready beat on a cycle with no full slot drops tvalid.
//  running_i falling: slots already full still drain; no flush.
//  clear_err_i: clears seq_err_o, align_err_o and drop counters the next cycle.
//   - Same-cycle set and clear: the set wins.
//  Async reset mid-transfer: tvalid drops immediately; every slot and counter returns to its reset value.
// STRUCTURE
//  Package pueo_trig_pkg:
//   - TRIG_SRC_SOFT=0, TRIG_SRC_PPS=1, TRIG_SRC_EXT=2, NUM_TRIG_SRC=3.
//   - typedef trig_entry_t {src, meta, addr}; META_RUN_BIT=7.
//  Sub-module pueo_trig_rx_slot, instantiated 3x:
//   - Contains edge detect, alignment and sequence checks, one-entry holding register and drop counter.
//   - Ports: full_o, grant_i, entry_o, err flags.
//  Top level: phase counter, round-robin arbiter, output register.
// TESTING
//  1. Run up; pps valid for 4 clks at phase+3, addr=0x123, meta=0x80; tready=1
//     -> one beat tdata={2'd1,8'h80,12'h123} at E+2; no errors.
//  2. Soft, pps and ext valid rise on the same cycle; tready=1
//     -> three beats in src order 0,1,2; next simultaneous set starts at src 0 again.
//  3. Ext meta sequence 0x80, 0x81, 0x83
//     -> seq_err_o=3'b100 after the third capture; a following 0x84 raises no new error; clear_err_i -> 0.
//  4. tready=0, soft pulses 3 times -> first entry held in the output reg, second held in the slot,
//     third dropped: drop_count soft=1.
//     Then release tready -> two beats.
//  5. Soft valid rises at phase+5 -> align_err_o=3'b001; entry still delivered.
//  6. Assert rst_i while tvalid=1 and tready=0 -> tvalid=0 immediately; after release, counters=0 and pointer=0.

Source files
------------

// File: rtl/pueo_trig_pkg.sv
// pueo_trig_pkg: shared source ids, widths and entry type for the TURF trigger receiver.
package pueo_trig_pkg;
    localparam int NUM_TRIG_SRC = 3;
    localparam logic [1:0] TRIG_SRC_SOFT = 2'd0;
    localparam logic [1:0] TRIG_SRC_PPS = 2'd1;
    localparam logic [1:0] TRIG_SRC_EXT = 2'd2;
    localparam int ADDR_BITS = 12;
    localparam int META_BITS = 8;
    localparam int META_RUN_BIT = 7;

    typedef struct packed {
        logic [1:0] src;
        logic [META_BITS-1:0] meta;
        logic [ADDR_BITS-1:0] addr;
    } trig_entry_t;

    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s == TRIG_SRC_EXT) ? TRIG_SRC_SOFT : s + 2'd1;
    endfunction
endpackage

// File: rtl/pueo_trig_rx_slot.sv
// pueo_trig_rx_slot: per-source edge capture, alignment/sequence checks, one-entry holding slot and drop counter.
module pueo_trig_rx_slot
    import pueo_trig_pkg::*;
#(
    parameter logic [1:0] SRC = TRIG_SRC_SOFT,
    parameter int CNT_BITS = 16
) (
    input  logic sysclk_i,
    input  logic rst_i,
    input  logic running_i,
    input  logic aligned_i,
    input  logic clear_err_i,
    input  logic [ADDR_BITS-1:0] trig_i,
    input  logic [META_BITS-1:0] meta_i,
    input  logic valid_i,
    input  logic grant_i,
    output logic full_o,
    output trig_entry_t entry_o,
    output logic [CNT_BITS-1:0] drop_count_o,
    output logic seq_err_o,
    output logic align_err_o
);
    logic valid_q;
    logic [META_RUN_BIT-1:0] exp_seq;
    logic cap, bad_seq, drop;
    logic [CNT_BITS-1:0] cnt_base;

    assign cap = valid_i & ~valid_q & running_i;
    assign bad_seq = cap & (~meta_i[META_RUN_BIT] | (meta_i[META_RUN_BIT-1:0] != exp_seq));
    assign drop = cap & full_o & ~grant_i;
    // a drop on the clearing cycle still counts, so the set wins
    assign cnt_base = clear_err_i ? '0 : drop_count_o;

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            exp_seq <= '0;
            full_o <= 1'b0;
            entry_o <= '0;
            drop_count_o <= '0;
            seq_err_o <= 1'b0;
            align_err_o <= 1'b0;
        end else begin
            valid_q <= valid_i;
            exp_seq <= ~running_i ? '0 : cap ? meta_i[META_RUN_BIT-1:0] + 1'b1 : exp_seq;
            full_o <= cap | (full_o & ~grant_i);
            if (cap & ~drop)
                entry_o <= {SRC, meta_i, trig_i};
            drop_count_o <= cnt_base + CNT_BITS'(drop & ~&cnt_base);
            seq_err_o <= (seq_err_o & ~clear_err_i) | bad_seq;
            align_err_o <= (align_err_o & ~clear_err_i) | (cap & ~aligned_i);
        end
    end
endmodule

// File: rtl/pueo_trig_rx_merge.sv
// pueo_trig_rx_merge: captures the soft/pps/ext TURF trigger streams and merges them
// round-robin onto one valid/ready stream for the event builder.
module pueo_trig_rx_merge
    import pueo_trig_pkg::*;
#(
    parameter int PHASE_OFFSET = 3,
    parameter int CNT_BITS = 16
) (
    input  logic sysclk_i,
    input  logic rst_i,
    input  logic sysclk_phase_i,
    input  logic running_i,
    input  logic clear_err_i,
    input  logic [ADDR_BITS-1:0] turf_soft_trig_i,
    input  logic [META_BITS-1:0] turf_soft_metadata_i,
    input  logic turf_soft_valid_i,
    input  logic [ADDR_BITS-1:0] turf_pps_trig_i,
    input  logic [META_BITS-1:0] turf_pps_metadata_i,
    input  logic turf_pps_valid_i,
    input  logic [ADDR_BITS-1:0] turf_ext_trig_i,
    input  logic [META_BITS-1:0] turf_ext_metadata_i,
    input  logic turf_ext_valid_i,
    output logic [$bits(trig_entry_t)-1:0] m_trig_tdata,
    output logic m_trig_tvalid,
    input  logic m_trig_tready,
    output logic [NUM_TRIG_SRC*CNT_BITS-1:0] drop_count_o,
    output logic [NUM_TRIG_SRC-1:0] seq_err_o,
    output logic [NUM_TRIG_SRC-1:0] align_err_o
);
    // counter reads 0 on the clock after the phase pulse, so the strobe lands PHASE_OFFSET clocks after it
    localparam logic [2:0] ALIGN_CNT = 3'(PHASE_OFFSET - 1);

    logic [2:0] phase_cnt;
    logic aligned, load, found;
    logic [1:0] ptr, gsrc, cand;
    logic [NUM_TRIG_SRC-1:0] full, grant, valid_all;
    logic [NUM_TRIG_SRC*ADDR_BITS-1:0] trig_all;
    logic [NUM_TRIG_SRC*META_BITS-1:0] meta_all;
    trig_entry_t entry [NUM_TRIG_SRC];

    assign trig_all = {turf_ext_trig_i, turf_pps_trig_i, turf_soft_trig_i};
    assign meta_all = {turf_ext_metadata_i, turf_pps_metadata_i, turf_soft_metadata_i};
    assign valid_all = {turf_ext_valid_i, turf_pps_valid_i, turf_soft_valid_i};
    assign aligned = phase_cnt == ALIGN_CNT;
    assign load = (~m_trig_tvalid | m_trig_tready) & |full;
    assign grant = load ? NUM_TRIG_SRC'(1) << gsrc : '0;

    always_comb begin
        gsrc = ptr;
        found = 1'b0;
        cand = ptr;
        for (int k = 0; k < NUM_TRIG_SRC; k++) begin
            if (!found && full[cand]) begin
                gsrc = cand;
                found = 1'b1;
            end
            cand = next_src(cand);
        end
    end

    for (genvar g = 0; g < NUM_TRIG_SRC; g++) begin : g_slot
        pueo_trig_rx_slot #(.SRC(2'(g)), .CNT_BITS(CNT_BITS)) u_slot (
            .sysclk_i(sysclk_i),
            .rst_i(rst_i),
            .running_i(running_i),
            .aligned_i(aligned),
            .clear_err_i(clear_err_i),
            .trig_i(trig_all[g*ADDR_BITS +: ADDR_BITS]),
            .meta_i(meta_all[g*META_BITS +: META_BITS]),
            .valid_i(valid_all[g]),
            .grant_i(grant[g]),
            .full_o(full[g]),
            .entry_o(entry[g]),
            .drop_count_o(drop_count_o[g*CNT_BITS +: CNT_BITS]),
            .seq_err_o(seq_err_o[g]),
            .align_err_o(align_err_o[g])
        );
    end

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_cnt <= '0;
            ptr <= TRIG_SRC_SOFT;
            m_trig_tdata <= '0;
            m_trig_tvalid <= 1'b0;
        end else begin
            phase_cnt <= sysclk_phase_i ? 3'd0 : phase_cnt + 3'd1;
            if (load) begin
                m_trig_tdata <= entry[gsrc];
                m_trig_tvalid <= 1'b1;
                ptr <= next_src(gsrc);
            end else if (m_trig_tready) begin
                m_trig_tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pueo_trig_rx_merge.sv
// tb_pueo_trig_rx_merge: directed checks of capture, sequencing, alignment, drops, arbitration and reset.
module tb_pueo_trig_rx_merge;
    logic sysclk_i = 1'b0;
    logic rst_i = 1'b1;
    logic sysclk_phase_i;
    logic running_i = 1'b0;
    logic clear_err_i = 1'b0;
    logic [11:0] addr = '0;
    logic [7:0] soft_meta = '0, pps_meta = '0, ext_meta = '0;
    logic [2:0] valid = '0;
    logic [21:0] m_trig_tdata;
    logic m_trig_tvalid;
    logic m_trig_tready = 1'b1;
    logic [47:0] drop_count_o;
    logic [2:0] seq_err_o, align_err_o;
    logic [31:0] cyc = '0;
    int checks = 0;
    int failures = 0;

    pueo_trig_rx_merge dut (
        .sysclk_i(sysclk_i),
        .rst_i(rst_i),
        .sysclk_phase_i(sysclk_phase_i),
        .running_i(running_i),
        .clear_err_i(clear_err_i),
        .turf_soft_trig_i(addr),
        .turf_soft_metadata_i(soft_meta),
        .turf_soft_valid_i(valid[0]),
        .turf_pps_trig_i(addr),
        .turf_pps_metadata_i(pps_meta),
        .turf_pps_valid_i(valid[1]),
        .turf_ext_trig_i(addr),
        .turf_ext_metadata_i(ext_meta),
        .turf_ext_valid_i(valid[2]),
        .m_trig_tdata(m_trig_tdata),
        .m_trig_tvalid(m_trig_tvalid),
        .m_trig_tready(m_trig_tready),
        .drop_count_o(drop_count_o),
        .seq_err_o(seq_err_o),
        .align_err_o(align_err_o)
    );

    always #5 sysclk_i = ~sysclk_i;
    always @(posedge sysclk_i) cyc <= cyc + 1;
    // the edge following a negedge with cyc%8==0 samples the phase pulse
    assign sysclk_phase_i = (cyc[2:0] == 3'd0);

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // raise the masked valids so the first capture edge is 'off' clocks after the phase pulse; held 4 clocks
    task automatic pulse(input logic [2:0] mask, input logic [2:0] off, input logic [11:0] a,
                         input logic [7:0] m0, input logic [7:0] m1, input logic [7:0] m2);
        do @(negedge sysclk_i); while (cyc[2:0] != off);
        addr = a;
        soft_meta = m0;
        pps_meta = m1;
        ext_meta = m2;
        valid = mask;
        fork
            begin
                repeat (4) @(negedge sysclk_i);
                valid = 3'b000;
            end
        join_none
    endtask

    task automatic expect_beat(input string tag, input logic [21:0] exp);
        int n = 0;
        while (!(m_trig_tvalid && m_trig_tready) && n < 20) begin
            @(negedge sysclk_i);
            n++;
        end
        chk({tag, "_vld"}, 48'(m_trig_tvalid), 48'd1);
        chk(tag, 48'(m_trig_tdata), 48'(exp));
        @(negedge sysclk_i);
    endtask

    task automatic clear_errs();
        @(negedge sysclk_i);
        clear_err_i = 1'b1;
        @(negedge sysclk_i);
        clear_err_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge sysclk_i);
        rst_i = 1'b0;
        chk("rst_tvalid", 48'(m_trig_tvalid), 48'd0);
        chk("rst_drop", drop_count_o, 48'd0);
        chk("rst_seq", 48'(seq_err_o), 48'd0);
        chk("rst_align", 48'(align_err_o), 48'd0);

        pulse(3'b001, 3'd3, 12'h055, 8'h80, 8'h00, 8'h00);
        repeat (6) @(negedge sysclk_i);
        chk("idle_tvalid", 48'(m_trig_tvalid), 48'd0);
        chk("idle_err", 48'({seq_err_o, align_err_o}), 48'd0);
        running_i = 1'b1;

        pulse(3'b010, 3'd3, 12'h123, 8'h00, 8'h80, 8'h00);
        @(negedge sysclk_i);
        chk("t1_e1_tvalid", 48'(m_trig_tvalid), 48'd0);
        @(negedge sysclk_i);
        chk("t1_e2_tvalid", 48'(m_trig_tvalid), 48'd1);
        chk("t1_data", 48'(m_trig_tdata), 48'({2'd1, 8'h80, 12'h123}));
        @(negedge sysclk_i);
        chk("t1_after", 48'(m_trig_tvalid), 48'd0);
        chk("t1_err", 48'({seq_err_o, align_err_o}), 48'd0);

        pulse(3'b100, 3'd3, 12'h300, 8'h00, 8'h00, 8'h80);
        expect_beat("t3_a", {2'd2, 8'h80, 12'h300});
        pulse(3'b100, 3'd3, 12'h301, 8'h00, 8'h00, 8'h81);
        expect_beat("t3_b", {2'd2, 8'h81, 12'h301});
        chk("t3_seq_ok", 48'(seq_err_o), 48'd0);
        pulse(3'b100, 3'd3, 12'h302, 8'h00, 8'h00, 8'h83);
        expect_beat("t3_c", {2'd2, 8'h83, 12'h302});
        chk("t3_seq_err", 48'(seq_err_o), 48'b100);
        pulse(3'b100, 3'd3, 12'h303, 8'h00, 8'h00, 8'h84);
        expect_beat("t3_d", {2'd2, 8'h84, 12'h303});
        chk("t3_seq_hold", 48'(seq_err_o), 48'b100);
        chk("t3_align", 48'(align_err_o), 48'd0);
        clear_errs();
        chk("t3_clear", 48'(seq_err_o), 48'd0);

        pulse(3'b111, 3'd3, 12'h200, 8'h80, 8'h81, 8'h85);
        expect_beat("t2_s0", {2'd0, 8'h80, 12'h200});
        expect_beat("t2_s1", {2'd1, 8'h81, 12'h200});
        expect_beat("t2_s2", {2'd2, 8'h85, 12'h200});
        pulse(3'b111, 3'd3, 12'h201, 8'h81, 8'h82, 8'h86);
        expect_beat("t2_r0", {2'd0, 8'h81, 12'h201});
        expect_beat("t2_r1", {2'd1, 8'h82, 12'h201});
        expect_beat("t2_r2", {2'd2, 8'h86, 12'h201});
        chk("t2_err", 48'({seq_err_o, align_err_o}), 48'd0);

        m_trig_tready = 1'b0;
        pulse(3'b001, 3'd3, 12'h400, 8'h82, 8'h00, 8'h00);
        repeat (2) @(negedge sysclk_i);
        chk("t4_hold_vld", 48'(m_trig_tvalid), 48'd1);
        pulse(3'b001, 3'd3, 12'h401, 8'h83, 8'h00, 8'h00);
        pulse(3'b001, 3'd3, 12'h402, 8'h84, 8'h00, 8'h00);
        repeat (4) @(negedge sysclk_i);
        chk("t4_drop", drop_count_o, 48'd1);
        chk("t4_hold_data", 48'(m_trig_tdata), 48'({2'd0, 8'h82, 12'h400}));
        m_trig_tready = 1'b1;
        expect_beat("t4_b1", {2'd0, 8'h82, 12'h400});
        expect_beat("t4_b2", {2'd0, 8'h83, 12'h401});
        chk("t4_empty", 48'(m_trig_tvalid), 48'd0);
        chk("t4_seq", 48'(seq_err_o), 48'd0);

        pulse(3'b001, 3'd5, 12'h500, 8'h85, 8'h00, 8'h00);
        expect_beat("t5_beat", {2'd0, 8'h85, 12'h500});
        chk("t5_align", 48'(align_err_o), 48'b001);
        chk("t5_seq", 48'(seq_err_o), 48'd0);
        clear_errs();
        chk("t5_clr_align", 48'(align_err_o), 48'd0);
        chk("t5_clr_drop", drop_count_o, 48'd0);

        m_trig_tready = 1'b0;
        pulse(3'b010, 3'd3, 12'h600, 8'h00, 8'h83, 8'h00);
        pulse(3'b010, 3'd3, 12'h601, 8'h00, 8'h84, 8'h00);
        pulse(3'b010, 3'd3, 12'h602, 8'h00, 8'h85, 8'h00);
        repeat (4) @(negedge sysclk_i);
        chk("t6_drop", drop_count_o, 48'h0000_0001_0000);
        chk("t6_vld", 48'(m_trig_tvalid), 48'd1);
        rst_i = 1'b1;
        #1;
        chk("t6_async_vld", 48'(m_trig_tvalid), 48'd0);
        chk("t6_async_drop", drop_count_o, 48'd0);
        repeat (2) @(negedge sysclk_i);
        rst_i = 1'b0;
        m_trig_tready = 1'b1;
        repeat (8) @(negedge sysclk_i);
        chk("t6_post_drop", drop_count_o, 48'd0);
        chk("t6_post_vld", 48'(m_trig_tvalid), 48'd0);
        pulse(3'b111, 3'd3, 12'h700, 8'h80, 8'h80, 8'h80);
        expect_beat("t6_s0", {2'd0, 8'h80, 12'h700});
        expect_beat("t6_s1", {2'd1, 8'h80, 12'h700});
        expect_beat("t6_s2", {2'd2, 8'h80, 12'h700});
        chk("t6_err", 48'({seq_err_o, align_err_o}), 48'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
